// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU logic-unit arbiter.
// Holds the opcode and FSM state encodings plus the stats counter width.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } alu_logic_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/alu_logic_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from last_grant+1, wrapping at N-1.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/alu_logic_arbiter.sv
// Round-robin shared NOT/AND/OR/XOR unit with a registered response channel.
// Define ALU_ARB_STATS_EN to add the saturating per-requester grant_cnt port.
module alu_logic_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][1:0]       req_op,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            rsp_data,
    output logic [IDW-1:0]              rsp_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][STAT_W-1:0] grant_cnt
`endif
);

    arb_state_e    state_q, state_d;
    alu_logic_op_e op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   gidx;
    logic             any_req;
    logic             accept;
    logic [WIDTH-1:0] alu_res;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (gidx),
        .any_req    (any_req)
    );

    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            (op_q == OP_NOT): alu_res = ~a_q;
            (op_q == OP_AND): alu_res = a_q & b_q;
            (op_q == OP_OR):  alu_res = a_q | b_q;
            (op_q == OP_XOR): alu_res = a_q ^ b_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        req_ready   = '0;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    op_d      = alu_logic_op_e'(req_op[gidx]);
                    a_d       = req_a[gidx];
                    b_d       = req_b[gidx];
                    id_d      = gidx;
                    last_d    = gidx;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_res;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Response registers stay frozen until the consumer takes it.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_NOT;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            last_q      <= IDW'(N_REQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] cnt_q, cnt_d;

    // Saturate rather than wrap so a long run never reads as idle.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q[gidx] != '1)) begin
            cnt_d[gidx] = cnt_q[gidx] + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/alu_logic_arbiter.md
# alu_logic_arbiter

Shared-resource controller for the 32-bit bitwise logic unit (NOT/AND/OR/XOR) in the ALU. Up to N_REQ requesters present operations over independent valid/ready channels. A round-robin arbiter grants one requester at a time. The block sequences the shared unit through a three-state FSM and returns a tagged, registered result on a single response channel with backpressure.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester operation valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_op  in  N_REQ×2  per-requester opcode: 00 NOT, 01 AND, 10 OR, 11 XOR
- req_a  in  N_REQ×WIDTH  per-requester operand A
- req_b  in  N_REQ×WIDTH  per-requester operand B (ignored for NOT)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  WIDTH  result
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns rsp_data
- grant_cnt  out  N_REQ×16  per-requester accepted-op count (only with ALU_ARB_STATS_EN)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, the arbiter selects index g and req_ready[g]=1 combinationally in the same cycle.
  - On the clock edge, op/a/b and g are latched, last_grant←g, and the FSM moves to EXEC.
  - If no req_valid is high, the FSM stays in IDLE and req_ready is all zero.
- EXEC: rsp_data←F(op,a,b), rsp_id←g, rsp_valid←1; the FSM moves to RESP.
- RESP:
  - rsp_valid is held high; rsp_data and rsp_id are stable.
  - On rsp_valid&rsp_ready: rsp_valid←0 and the FSM returns to IDLE.
  - Otherwise the FSM stays in RESP indefinitely.
- Function F:
  - NOT: ~a
  - AND: a&b
  - OR: a|b
  - XOR: a^b
  - All results are WIDTH bits, with no carry or flags.
- Round-robin arbitration:
  - Search starts at (last_grant+1) mod N_REQ and grants the first index with req_valid high.
  - Index wrap from N_REQ-1 to 0 is required.
- req_ready is 0 in EXEC and RESP regardless of req_valid.
- A requester may drop req_valid before it is granted; nothing is latched for it.
- A requester must hold its req_* fields stable while req_valid=1 and req_ready=0.
- Out-of-range rsp_id never occurs; unused grant indices are unreachable.

## Timing
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0
  - last_grant=N_REQ-1, so requester 0 has first priority
  - req_ready=0 (outputs are combinational from the reset state, so it is 0 with no valid)
  - grant_cnt=0
- Latency: with acceptance on edge E, rsp_valid is high after edge E+1.
- Throughput: with rsp_ready held high, the handshake completes at edge E+2 and the next acceptance is at edge E+3, i.e. one operation per 3 cycles.
- Simultaneous valids: exactly one grant per IDLE cycle.
- Reset asserted mid-operation (EXEC or RESP): the in-flight op is discarded, rsp_valid drops immediately (async), and arbitration priority returns to requester 0.
- rsp_ready asserted while rsp_valid=0 has no effect.

## Configuration
- ALU_ARB_STATS_EN defined:
  - grant_cnt is present.
  - Entry i increments by 1 on each acceptance of requester i.
  - The counter saturates at 16'hFFFF and does not wrap.
- ALU_ARB_STATS_EN undefined:
  - The grant_cnt port and its counters are absent.
  - All other behaviour is identical.

## Structure
- Package alu_arb_pkg:
  - alu_logic_op_e enum (NOT/AND/OR/XOR = 2'b00..2'b11)
  - arb_state_e enum (IDLE/EXEC/RESP)
  - STAT_W=16
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational.
- The logic function is an inline case in the top; no separate module.

## Test plan
- Single NOT: req0 valid, op=00, a=32'h0000000E.
  - req_ready[0] is high in the same cycle.
  - Two edges later: rsp_valid=1, rsp_data=32'hFFFFFFF1, rsp_id=0.
- All ops on requester 2 with a=32'hF0F0_00B4, b=32'h0FF0_0607:
  - AND → 32'h00F0_0004
  - OR → 32'hFFF0_06B7
  - XOR → 32'hFF00_06B3
  - rsp_id=2 for each.
- Fairness: all 4 requesters valid continuously, rsp_ready=1.
  - Grant order is 0,1,2,3,0,1.
  - Acceptances are exactly 3 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_data and rsp_id stay stable.
  - req_ready stays all zero.
  - With rsp_ready=1, the next grant occurs the cycle after the handshake.
- Reset mid-RESP:
  - rst_n low while rsp_valid=1: rsp_valid goes to 0 asynchronously.
  - After release, with req1 and req3 both valid: grant goes to req1 first.
- ALU_ARB_STATS_EN: force grant_cnt[0] to 16'hFFFE, then issue 3 req0 ops.
  - grant_cnt[0] ends at 16'hFFFF with no wrap.
  - The other entries are unchanged.
